// File: rtl/uart_pkg.sv
// ------------------------------------------------------------------
// uart_pkg: shared UART definitions (state encoding, frame sizing).
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_DONE  = 2'd3
  } rx_state_e;

  localparam int SR_W     = 10;
  localparam int STOP_IDX = SR_W - 1;
  localparam int BITS_MIN = 8;
  localparam int BITS_MAX = 10;
  localparam int CNT_W    = $clog2(BITS_MAX + 1);

  // Shifts per frame after the start bit: 7 data + optional 8th + optional parity + stop.
  function automatic logic [CNT_W-1:0] frame_bits(input logic eight, input logic pen);
    logic [CNT_W-1:0] n;
    n = CNT_W'(BITS_MIN);
    if (eight) n = n + CNT_W'(1);
    if (pen)   n = n + CNT_W'(1);
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bit_timer.sv
// ------------------------------------------------------------------
// bit_timer: loadable down-counter that holds at zero; expired = count is 0.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module bit_timer #(
  parameter int BAUD_W = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [BAUD_W-1:0] load_val,
  output logic              expired
);

  logic [BAUD_W-1:0] cnt_q;
  logic [BAUD_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - BAUD_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/uart_rx_engine.sv
// ------------------------------------------------------------------
// uart_rx_engine: UART receive controller driving an external 10-bit SIPO.
// Parity support compiled in with `UART_RX_PARITY_EN. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module uart_rx_engine
  import uart_pkg::*;
#(
  parameter int BAUD_W = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  input  logic [BAUD_W-1:0] baud_k,
  input  logic              eight,
  input  logic              pen,
  input  logic              ohel,
  input  logic [SR_W-1:0]   sr_data,
  input  logic              rd_clr,
  output logic              shift,
  output logic              sdi,
  output logic [7:0]        rx_data,
  output logic              rxrdy,
  output logic              perr,
  output logic              ferr,
  output logic              ovf
);

  logic             sync1_q, sync1_d;
  logic             rx_s_q, rx_s_d;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             eight_q, eight_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rxrdy_q, rxrdy_d;
  logic             perr_q, perr_d;
  logic             ferr_q, ferr_d;
  logic             ovf_q, ovf_d;

  logic              tmr_load;
  logic [BAUD_W-1:0] tmr_val;
  logic              tmr_exp;
  logic              cfg_load;
  logic              frame_pen;
  logic [7:0]        frame_data;
  logic              par_err;
  logic [CNT_W-1:0]  n_bits;
  logic [CNT_W-1:0]  bit_cnt_inc;

  bit_timer #(.BAUD_W(BAUD_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_exp)
  );

  assign sync1_d  = rx;
  assign rx_s_d   = sync1_q;
  assign cfg_load = (state_q == ST_IDLE) && !rx_s_q;
  assign eight_d  = cfg_load ? eight : eight_q;

`ifdef UART_RX_PARITY_EN
  logic pen_q, pen_d;
  logic ohel_q, ohel_d;
  logic par_bit;

  assign pen_d     = cfg_load ? pen  : pen_q;
  assign ohel_d    = cfg_load ? ohel : ohel_q;
  assign frame_pen = pen_q;
  assign par_bit   = sr_data[8];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pen_q  <= 1'b0;
      ohel_q <= 1'b0;
    end else begin
      pen_q  <= pen_d;
      ohel_q <= ohel_d;
    end
  end

  // Right-shifting SIPO: the stop bit lands at the top, data ends up below it.
  always_comb begin
    frame_data = '0;
    case ({eight_q, pen_q})
      2'b11:   frame_data = sr_data[7:0];
      2'b10:   frame_data = sr_data[8:1];
      2'b01:   frame_data = {1'b0, sr_data[7:1]};
      default: frame_data = {1'b0, sr_data[8:2]};
    endcase
  end

  assign par_err = pen_q & (^frame_data ^ par_bit ^ ohel_q);
`else
  logic unused_par_inputs;

  assign frame_pen         = 1'b0;
  assign frame_data        = eight_q ? sr_data[8:1] : {1'b0, sr_data[8:2]};
  assign par_err           = 1'b0;
  assign unused_par_inputs = pen ^ ohel ^ sr_data[0];
`endif

  assign n_bits      = frame_bits(eight_q, frame_pen);
  assign bit_cnt_inc = bit_cnt_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    shift     = 1'b0;
    rx_data_d = rx_data_q;
    rxrdy_d   = rxrdy_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    ovf_d     = ovf_q;

    if (rd_clr) begin
      rxrdy_d = 1'b0;
      perr_d  = 1'b0;
      ferr_d  = 1'b0;
      ovf_d   = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (!rx_s_q) begin
          tmr_load = 1'b1;
          tmr_val  = baud_k >> 1;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (tmr_exp) begin
          if (rx_s_q) begin
            state_d = ST_IDLE;
          end else begin
            tmr_load  = 1'b1;
            tmr_val   = baud_k - BAUD_W'(1);
            bit_cnt_d = '0;
            state_d   = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (tmr_exp) begin
          shift     = 1'b1;
          bit_cnt_d = bit_cnt_inc;
          tmr_load  = 1'b1;
          tmr_val   = baud_k - BAUD_W'(1);
          if (bit_cnt_inc == n_bits) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // A read in this same cycle consumes the old frame, so no overrun.
        rx_data_d = frame_data;
        rxrdy_d   = 1'b1;
        ferr_d    = ~sr_data[STOP_IDX];
        perr_d    = par_err;
        ovf_d     = rd_clr ? 1'b0 : (ovf_q | rxrdy_q);
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      eight_q   <= 1'b0;
      rx_data_q <= '0;
      rxrdy_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      rx_s_q    <= rx_s_d;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      eight_q   <= eight_d;
      rx_data_q <= rx_data_d;
      rxrdy_q   <= rxrdy_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      ovf_q     <= ovf_d;
    end
  end

  assign sdi     = shift & rx_s_q;
  assign rx_data = rx_data_q;
  assign rxrdy   = rxrdy_q;
  assign perr    = perr_q;
  assign ferr    = ferr_q;
  assign ovf     = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_engine.sv
// ------------------------------------------------------------------
// tb_uart_rx_engine: directed frames with a scoreboard of expected bytes/flags.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_uart_rx_engine;

  localparam int BAUD_W = 19;
  localparam int K      = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              rx;
  logic [BAUD_W-1:0] baud_k;
  logic              eight, pen, ohel, rd_clr;
  logic [9:0]        sr_data;
  logic              shift, sdi, rxrdy, perr, ferr, ovf;
  logic [7:0]        rx_data;

  always #5 clk = ~clk;

  uart_rx_engine #(.BAUD_W(BAUD_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .rx      (rx),
    .baud_k  (baud_k),
    .eight   (eight),
    .pen     (pen),
    .ohel    (ohel),
    .sr_data (sr_data),
    .rd_clr  (rd_clr),
    .shift   (shift),
    .sdi     (sdi),
    .rx_data (rx_data),
    .rxrdy   (rxrdy),
    .perr    (perr),
    .ferr    (ferr),
    .ovf     (ovf)
  );

  // Downstream SIPO: shifts right, new bit enters at the top.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      sr_data <= '0;
    else if (shift) sr_data <= {sdi, sr_data[9:1]};
  end

  int cyc = 0;
  int shift_cnt = 0;
  int shift_cyc[$];

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (shift) begin
      shift_cnt = shift_cnt + 1;
      shift_cyc.push_back(cyc);
    end
  end

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   m_rdy  = 1'b0;
  bit   m_ovf  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (K) @(negedge clk);
  endtask

  task automatic clr();
    rd_clr = 1'b1;
    @(negedge clk);
    rd_clr = 1'b0;
    m_rdy = 1'b0;
    m_ovf = 1'b0;
    @(negedge clk);
  endtask

  // par_flip inverts the correct parity bit; clr_at_done means a read hits the DONE cycle.
  task automatic send_frame(input logic [7:0] d, input logic stop_b,
                            input logic par_flip, input bit clr_at_done);
    logic [7:0] dm;
    logic       par;
    int         nd;
    exp_t       e;
    nd     = eight ? 8 : 7;
    dm     = eight ? d : {1'b0, d[6:0]};
    par    = (^dm) ^ ohel ^ par_flip;
    e.data = dm;
    e.ferr = ~stop_b;
    e.perr = PAR_EN && pen && par_flip;
    e.ovf  = clr_at_done ? 1'b0 : (m_ovf | m_rdy);
    m_ovf  = e.ovf;
    m_rdy  = 1'b1;
    sb.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < nd; i++) drive_bit(dm[i]);
    if (PAR_EN && pen) drive_bit(par);
    drive_bit(stop_b);
    rx = 1'b1;
  endtask

  task automatic check_frame(input string tag);
    exp_t e;
    chk({tag, "_sb_level"}, sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_rx_data"}, rx_data, e.data);
      chk({tag, "_rxrdy"}, rxrdy, 1'b1);
      chk({tag, "_perr"}, perr, e.perr);
      chk({tag, "_ferr"}, ferr, e.ferr);
      chk({tag, "_ovf"}, ovf, e.ovf);
    end
  endtask

  int base_cnt;
  int base_idx;
  bit hit;

  initial begin
    reset  = 1'b1;
    rx     = 1'b1;
    baud_k = BAUD_W'(K);
    eight  = 1'b1;
    pen    = 1'b0;
    ohel   = 1'b0;
    rd_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rxrdy", rxrdy, 1'b0);
    chk("rst_flags", {perr, ferr, ovf, shift, sdi}, 5'b0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // 8N1 0xA5: shift count and spacing
    base_cnt = shift_cnt;
    base_idx = shift_cyc.size();
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("a5_shift_count", shift_cnt - base_cnt, 9);
    for (int i = base_idx + 1; i < shift_cyc.size(); i++)
      chk("a5_shift_gap", shift_cyc[i] - shift_cyc[i-1], K);
    check_frame("a5");
    clr();
    chk("a5_cleared_rxrdy", rxrdy, 1'b0);

    // 7-bit, parity requested: bad then good parity bit
    eight = 1'b0;
    pen   = 1'b1;
    ohel  = 1'b0;
    send_frame(8'hB5, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check_frame("p35_bad");
    clr();
    send_frame(8'h35, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check_frame("p35_good");
    clr();

    // Framing error, then the low line yields a false start only
    eight = 1'b1;
    pen   = 1'b0;
    base_cnt = shift_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (3 * K) @(negedge clk);
    chk("ferr_shift_count", shift_cnt - base_cnt, 9);
    check_frame("ferr3c");
    clr();

    // Glitch of 3 clocks
    base_cnt = shift_cnt;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (3 * K) @(negedge clk);
    chk("glitch_shift_count", shift_cnt - base_cnt, 0);
    chk("glitch_rxrdy", rxrdy, 1'b0);

    // Overrun: two frames without a read
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    check_frame("ovf11");
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check_frame("ovf22");

    // Third frame with rd_clr in its DONE cycle
    base_cnt = shift_cnt;
    hit = 1'b0;
    fork
      send_frame(8'h33, 1'b1, 1'b0, 1'b1);
      begin
        for (int t = 0; t < 12 * K && !hit; t++) begin
          @(negedge clk);
          if (shift_cnt == base_cnt + 9) hit = 1'b1;
        end
        chk("clr_done_seen", hit, 1'b1);
        rd_clr = 1'b1;
        @(negedge clk);
        rd_clr = 1'b0;
      end
    join
    @(negedge clk);
    check_frame("clr33");

    // Reset after the 4th data shift
    base_cnt = shift_cnt;
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    rx = 1'b1;
    hit = 1'b0;
    for (int t = 0; t < 2 * K && !hit; t++) begin
      @(negedge clk);
      if (shift_cnt == base_cnt + 4) hit = 1'b1;
    end
    chk("rst_4th_shift_seen", hit, 1'b1);
    reset = 1'b1;
    #1;
    chk("midrst_rx_data", rx_data, 8'h00);
    chk("midrst_rxrdy", rxrdy, 1'b0);
    chk("midrst_perr", perr, 1'b0);
    chk("midrst_ferr", ferr, 1'b0);
    chk("midrst_ovf", ovf, 1'b0);
    chk("midrst_shift_sdi", {shift, sdi}, 2'b00);
    m_rdy = 1'b0;
    m_ovf = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2 * K) @(negedge clk);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check_frame("post_rst5a");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
